// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// counter_pkg : shared defaults for the counter block.   Rev 1.0
// ============================================================================
package counter_pkg;
    localparam int COUNTER_WIDTH_DEF = 5;
endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_if.sv
`default_nettype none
// ============================================================================
// counter_if : groups enable / count / wrap of one counter instance.   Rev 1.0
// ============================================================================
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEF
);
    logic             enable;
    logic [WIDTH-1:0] counter_out;
    logic             wrap;

    modport master (output enable, input  counter_out, input  wrap);
    modport slave  (input  enable, output counter_out, output wrap);
endinterface : counter_if
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// counter : modulo-(MAX_COUNT+1) up-counter with registered wrap pulse.
// COUNTER_SATURATE_EN: hold at MAX_COUNT, wrap becomes a level.   Rev 1.0
// ============================================================================
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = COUNTER_WIDTH_DEF,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
)(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             enable,
    output      logic [WIDTH-1:0] counter_out,
    output      logic             wrap
);

    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
`ifdef COUNTER_SATURATE_EN
        if (enable) begin
            count_d = (count_q >= MAX_COUNT) ? MAX_COUNT : count_q + c_ONE;
        end
        // Level: tracks the value the count register is about to hold.
        wrap_d = (count_d == MAX_COUNT);
`else
        if (enable) begin
            // >= also recovers an out-of-range (upset) value back to zero.
            if (count_q >= MAX_COUNT) begin
                count_d = c_ZERO;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + c_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= c_ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign counter_out = count_q;
    assign wrap        = wrap_q;

endmodule : counter
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// tb_counter : directed self-checking bench for counter (5-bit default).
// Rev 1.0
// ============================================================================
module tb_counter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   pulses;

    counter_if #(.WIDTH(5)) u_if ();

    counter #(.WIDTH(5)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (u_if.enable),
        .counter_out (u_if.counter_out),
        .wrap        (u_if.wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int exp_cnt, input int exp_wrap);
        check_eq({tag, "_cnt"},  int'(u_if.counter_out), exp_cnt);
        check_eq({tag, "_wrap"}, int'(u_if.wrap),        exp_wrap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        pulses      = 0;
        reset       = 1'b1;
        u_if.enable = 1'b1;

        #1;
        check_state("rst_t1", 0, 0);
        step();                                  // edge at 5 ns under reset
        check_state("rst_edge", 0, 0);
        #4 reset = 1'b0;                         // release at 10 ns

        step(); check_state("rel_e1", 1, 0);     // 15 ns
        step(); check_state("rel_e2", 2, 0);     // 25 ns
        step(); check_state("rel_e3", 3, 0);     // 35 ns

        for (int i = 0; i < 4; i++) step();
        check_state("at7", 7, 0);
        u_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("hold", 7, 0);
        end
        u_if.enable = 1'b1;
        step(); check_state("reen", 8, 0);

        for (int i = 0; i < 23; i++) step();
`ifdef COUNTER_SATURATE_EN
        check_state("at31", 31, 1);
        step(); check_state("sat1", 31, 1);
        step(); check_state("sat2", 31, 1);
        #3 reset = 1'b1;
        #1 check_state("sat_rst", 0, 0);
        step(); check_state("sat_rst_hold", 0, 0);
        #3 reset = 1'b0;
        step(); check_state("sat_rel", 1, 0);
`else
        check_state("at31", 31, 0);
        step(); check_state("wrap0", 0, 1);
        step(); check_state("wrap1", 1, 0);

        // 64 enabled edges from 1 pass through 31->0 exactly twice.
        for (int i = 0; i < 64; i++) begin
            step();
            if (u_if.wrap) pulses++;
        end
        check_eq("wrap_pulses", pulses, 2);
        check_state("after64", 1, 0);

        for (int i = 0; i < 19; i++) step();
        check_state("at20", 20, 0);
        #3 reset = 1'b1;                         // mid-cycle, away from edges
        #1 check_state("async_rst", 0, 0);
        step(); check_state("rst_hold", 0, 0);
        #3 reset = 1'b0;
        step(); check_state("rst_rel", 1, 0);
        step(); check_state("rst_rel2", 2, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter
`default_nettype wire
